// File: rtl/instr_register_calc.sv
// Instruction register file with a registered execute stage on the read path.
// Define INSTR_REG_BYPASS_EN to forward same-cycle write data to a read of the same entry.
module instr_register_calc #(
  parameter int DEPTH = 32,
  parameter int OP_W  = 32,
  localparam int IDX_W = $clog2(DEPTH)
) (
  input  logic                  clk,
  input  logic                  reset_en,
  input  logic                  load_en,
  input  logic [IDX_W-1:0]      write_index,
  input  logic [2:0]            opcode,
  input  logic [OP_W-1:0]       operand_a,
  input  logic [OP_W-1:0]       operand_b,
  input  logic                  read_en,
  input  logic [IDX_W-1:0]      read_index,
  output logic                  rd_valid,
  output logic [3+2*OP_W-1:0]   instruction,
  output logic [2*OP_W-1:0]     result,
  output logic                  entry_valid,
  output logic                  div_err,
  output logic [IDX_W:0]        count
);

  typedef enum logic [2:0] {
    ZERO  = 3'd0,
    PASSA = 3'd1,
    PASSB = 3'd2,
    ADD   = 3'd3,
    SUB   = 3'd4,
    MULT  = 3'd5,
    DIV   = 3'd6,
    MOD   = 3'd7
  } opcode_t;

  localparam logic [IDX_W:0] DEPTH_L = (IDX_W+1)'(DEPTH);

  opcode_t             r_opcMem [DEPTH];
  logic [OP_W-1:0]     r_aMem   [DEPTH];
  logic [OP_W-1:0]     r_bMem   [DEPTH];
  logic [DEPTH-1:0]    r_valid;
  logic [IDX_W:0]      r_count;

  logic                r_rdValid;
  logic [3+2*OP_W-1:0] r_instr;
  logic [2*OP_W-1:0]   r_result;
  logic                r_entryValid;
  logic                r_divErr;

  logic                w_wrOk;
  logic                w_rdOk;
  logic                w_bypass;
  logic [IDX_W-1:0]    w_rdIdx;
  opcode_t             w_selOpc;
  logic [OP_W-1:0]     w_selA;
  logic [OP_W-1:0]     w_selB;
  logic                w_selValid;
  logic signed [2*OP_W-1:0] w_aExt;
  logic signed [2*OP_W-1:0] w_bExt;
  logic signed [2*OP_W-1:0] w_result;
  logic                w_divErr;

  assign w_wrOk  = load_en && ({1'b0, write_index} < DEPTH_L);
  assign w_rdOk  = {1'b0, read_index} < DEPTH_L;
  // Clamp keeps the array lookup in range; w_rdOk masks the data afterwards.
  assign w_rdIdx = w_rdOk ? read_index : '0;

`ifdef INSTR_REG_BYPASS_EN
  assign w_bypass = w_wrOk && read_en && (write_index == read_index);
`else
  assign w_bypass = 1'b0;
`endif

  always_comb begin
    w_selValid = w_rdOk && r_valid[w_rdIdx];
    w_selOpc   = r_opcMem[w_rdIdx];
    w_selA     = r_aMem[w_rdIdx];
    w_selB     = r_bMem[w_rdIdx];
    if (w_bypass) begin
      w_selValid = 1'b1;
      w_selOpc   = opcode_t'(opcode);
      w_selA     = operand_a;
      w_selB     = operand_b;
    end
  end

  assign w_aExt = {{OP_W{w_selA[OP_W-1]}}, w_selA};
  assign w_bExt = {{OP_W{w_selB[OP_W-1]}}, w_selB};

  // Operands are widened first so the full product and INT_MIN / -1 are exact.
  always_comb begin
    w_result = '0;
    w_divErr = 1'b0;
    case (w_selOpc)
      ZERO:  w_result = '0;
      PASSA: w_result = w_aExt;
      PASSB: w_result = w_bExt;
      ADD:   w_result = w_aExt + w_bExt;
      SUB:   w_result = w_aExt - w_bExt;
      MULT:  w_result = w_aExt * w_bExt;
      DIV: begin
        if (w_selB == '0) w_divErr = 1'b1;
        else              w_result = w_aExt / w_bExt;
      end
      MOD: begin
        if (w_selB == '0) w_divErr = 1'b1;
        else              w_result = w_aExt % w_bExt;
      end
      default: w_result = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_wrOk && !reset_en) begin
      r_opcMem[write_index] <= opcode_t'(opcode);
      r_aMem[write_index]   <= operand_a;
      r_bMem[write_index]   <= operand_b;
    end
  end

  always_ff @(posedge clk) begin
    if (reset_en) begin
      r_valid <= '0;
      r_count <= '0;
    end else if (w_wrOk) begin
      r_valid[write_index] <= 1'b1;
      if (!r_valid[write_index]) r_count <= r_count + (IDX_W+1)'(1);
    end
  end

  // Response outputs hold their last value on cycles without a read.
  always_ff @(posedge clk) begin
    if (reset_en) begin
      r_rdValid    <= 1'b0;
      r_instr      <= '0;
      r_result     <= '0;
      r_entryValid <= 1'b0;
      r_divErr     <= 1'b0;
    end else begin
      r_rdValid <= read_en;
      if (read_en) begin
        r_entryValid <= w_selValid;
        r_instr      <= w_selValid ? {w_selOpc, w_selA, w_selB} : '0;
        r_result     <= w_selValid ? w_result : '0;
        r_divErr     <= w_selValid && w_divErr;
      end
    end
  end

  assign rd_valid    = r_rdValid;
  assign instruction = r_instr;
  assign result      = r_result;
  assign entry_valid = r_entryValid;
  assign div_err     = r_divErr;
  assign count       = r_count;

endmodule

// File: tb/tb_instr_register_calc.sv
// Scoreboard bench for instr_register_calc: stimulus pushes expected responses, a monitor pops them.
// Build with or without INSTR_REG_BYPASS_EN; the reference model follows the same macro.
module tb_instr_register_calc;

  localparam int DEPTH = 32;
  localparam int OP_W  = 32;
  localparam int ZERO = 0, PASSA = 1, PASSB = 2, ADD = 3, SUB = 4, MULT = 5, DIV = 6, MOD = 7;

  typedef struct {
    logic        ev;
    logic [66:0] instr;
    logic [63:0] res;
    logic        err;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset_en = 1'b1;
  logic        load_en = 1'b0;
  logic [4:0]  write_index = '0;
  logic [2:0]  opcode = '0;
  logic [31:0] operand_a = '0;
  logic [31:0] operand_b = '0;
  logic        read_en = 1'b0;
  logic [4:0]  read_index = '0;
  logic        rd_valid;
  logic [66:0] instruction;
  logic [63:0] result;
  logic        entry_valid;
  logic        div_err;
  logic [5:0]  count;

  logic        ld20 = 1'b0;
  logic [4:0]  widx20 = '0;
  logic [2:0]  opc20 = '0;
  logic [31:0] a20 = '0;
  logic [31:0] b20 = '0;
  logic        rd20 = 1'b0;
  logic [4:0]  ridx20 = '0;
  logic        rdValid20;
  logic [66:0] instr20;
  logic [63:0] result20;
  logic        entryValid20;
  logic        divErr20;
  logic [5:0]  count20;

  int   nTests = 0;
  int   nFail  = 0;
  bit   chkEn  = 1'b0;
  exp_t scq[$];
  int   expCount = 0;

  int   mOpc [DEPTH];
  int   mA   [DEPTH];
  int   mB   [DEPTH];
  bit   mValid [DEPTH];
  int   mCount = 0;

  instr_register_calc #(.DEPTH(DEPTH), .OP_W(OP_W)) u_dut (
    .clk(clk), .reset_en(reset_en), .load_en(load_en), .write_index(write_index),
    .opcode(opcode), .operand_a(operand_a), .operand_b(operand_b),
    .read_en(read_en), .read_index(read_index), .rd_valid(rd_valid),
    .instruction(instruction), .result(result), .entry_valid(entry_valid),
    .div_err(div_err), .count(count)
  );

  instr_register_calc #(.DEPTH(20), .OP_W(OP_W)) u_dut20 (
    .clk(clk), .reset_en(reset_en), .load_en(ld20), .write_index(widx20),
    .opcode(opc20), .operand_a(a20), .operand_b(b20),
    .read_en(rd20), .read_index(ridx20), .rd_valid(rdValid20),
    .instruction(instr20), .result(result20), .entry_valid(entryValid20),
    .div_err(divErr20), .count(count20)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string nm, input logic [127:0] act, input logic [127:0] exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic void calc(input int opc, input int a, input int b,
                               output longint r, output bit err);
    r = 0;
    err = 1'b0;
    case (opc)
      PASSA: r = a;
      PASSB: r = b;
      ADD:   r = longint'(a) + longint'(b);
      SUB:   r = longint'(a) - longint'(b);
      MULT:  r = longint'(a) * longint'(b);
      DIV:   if (b == 0) err = 1'b1; else r = longint'(a) / longint'(b);
      MOD:   if (b == 0) err = 1'b1; else r = longint'(a) % longint'(b);
      default: r = 0;
    endcase
  endfunction

  // Called at a falling edge; drives one cycle of inputs and predicts the response.
  task automatic applyStimulus(input bit rst, input bit ld, input int widx, input int opc,
                               input int a, input int b, input bit rd, input int ridx);
    exp_t   e;
    bit     useNew;
    bit     v;
    int     o, x, y;
    longint r;
    bit     err;
    reset_en    = rst;
    load_en     = ld;
    write_index = 5'(widx);
    opcode      = 3'(opc);
    operand_a   = 32'(a);
    operand_b   = 32'(b);
    read_en     = rd;
    read_index  = 5'(ridx);
    e = '{ev: 1'b0, instr: '0, res: '0, err: 1'b0};
    if (rst) begin
      foreach (mValid[i]) mValid[i] = 1'b0;
      mCount = 0;
    end else begin
      if (rd) begin
        useNew = 1'b0;
`ifdef INSTR_REG_BYPASS_EN
        useNew = ld && (widx == ridx) && (widx < DEPTH);
`endif
        v = 1'b0; o = 0; x = 0; y = 0;
        if (useNew) begin
          v = 1'b1; o = opc; x = a; y = b;
        end else if (ridx < DEPTH && mValid[ridx]) begin
          v = 1'b1; o = mOpc[ridx]; x = mA[ridx]; y = mB[ridx];
        end
        if (v) begin
          calc(o, x, y, r, err);
          e.ev    = 1'b1;
          e.instr = {o[2:0], x, y};
          e.res   = r;
          e.err   = err;
        end
      end
      if (ld && widx < DEPTH) begin
        if (!mValid[widx]) mCount++;
        mValid[widx] = 1'b1;
        mOpc[widx] = opc;
        mA[widx] = a;
        mB[widx] = b;
      end
    end
    @(posedge clk);
    if (rd && !rst) scq.push_back(e);
    expCount = mCount;
    if (rst) chkEn = 1'b1;
    @(negedge clk);
  endtask

  // Scoreboard monitor: one response is owed exactly for each read issued last cycle.
  always @(negedge clk) begin
    exp_t e;
    if (chkEn) begin
      checkOutput("rd_valid", 128'(rd_valid), 128'(scq.size() != 0));
      checkOutput("count", 128'(count), 128'(expCount));
      if (scq.size() != 0) begin
        e = scq.pop_front();
        if (rd_valid) begin
          checkOutput("entry_valid", 128'(entry_valid), 128'(e.ev));
          checkOutput("instruction", 128'(instruction), 128'(e.instr));
          checkOutput("result", 128'(result), 128'(e.res));
          checkOutput("div_err", 128'(div_err), 128'(e.err));
        end
      end
    end
  end

  function automatic int randOperand();
    int sel;
    sel = int'($urandom_range(0, 4));
    if (sel == 0) return 0;
    if (sel < 3)  return int'($urandom_range(0, 40)) - 20;
    return int'($urandom);
  endfunction

  initial begin
    int opc, a, b;
    @(negedge clk);
    repeat (3) applyStimulus(1, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 0);

    applyStimulus(0, 1, 0, ADD, 5, 7, 0, 0);
    applyStimulus(0, 1, 1, SUB, 3, 10, 0, 0);
    applyStimulus(0, 1, 2, MULT, -4, 6, 0, 0);
    applyStimulus(0, 1, 3, MOD, -7, 3, 0, 0);
    for (int i = 0; i < 4; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, i);

    applyStimulus(0, 1, 2, DIV, 9, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2);
    applyStimulus(0, 1, 2, DIV, 9, 2, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 2);

    applyStimulus(0, 1, 5, ADD, 1, 1, 1, 5);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 5);

    applyStimulus(0, 1, 8, DIV, 32'h8000_0000, -1, 0, 0);
    applyStimulus(0, 1, 9, MULT, 32'h8000_0000, 32'h8000_0000, 0, 0);
    applyStimulus(0, 1, 10, SUB, 32'h8000_0000, 32'h7fff_ffff, 0, 0);
    applyStimulus(0, 1, 11, MOD, 7, -3, 1, 8);
    for (int i = 8; i < 12; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, i);

    for (int i = 0; i < DEPTH; i++) begin
      opc = int'($urandom_range(0, 7));
      a = randOperand();
      b = randOperand();
      applyStimulus(0, 1, i, opc, a, b, 0, 0);
    end
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, i);
    applyStimulus(0, 1, 31, PASSB, 0, -123, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 1, 31);

    for (int i = 0; i < 80; i++) begin
      applyStimulus(0, 1'($urandom_range(0, 1)), int'($urandom_range(0, 7)),
                    int'($urandom_range(0, 7)), randOperand(), randOperand(),
                    1'($urandom_range(0, 1)), int'($urandom_range(0, 7)));
    end
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    // Non-power-of-two instance: index 25 lies beyond its 20 entries.
    ld20 = 1'b1; widx20 = 5'd25; opc20 = 3'(ADD); a20 = 32'd1; b20 = 32'd1;
    @(negedge clk);
    ld20 = 1'b0; rd20 = 1'b1; ridx20 = 5'd25;
    @(negedge clk);
    rd20 = 1'b0;
    checkOutput("d20 rd_valid", 128'(rdValid20), 128'(1));
    checkOutput("d20 entry_valid oob", 128'(entryValid20), 128'(0));
    checkOutput("d20 result oob", 128'(result20), 128'(0));
    checkOutput("d20 count oob", 128'(count20), 128'(0));
    ld20 = 1'b1; widx20 = 5'd19; opc20 = 3'(ADD); a20 = 32'd2; b20 = 32'd3;
    @(negedge clk);
    ld20 = 1'b0; rd20 = 1'b1; ridx20 = 5'd19;
    @(negedge clk);
    rd20 = 1'b0;
    checkOutput("d20 entry_valid 19", 128'(entryValid20), 128'(1));
    checkOutput("d20 result 19", 128'(result20), 128'(5));
    checkOutput("d20 count 19", 128'(count20), 128'(1));

    applyStimulus(0, 0, 0, 0, 0, 0, 1, 3);
    applyStimulus(1, 1, 4, ADD, 1, 2, 1, 0);
    for (int i = 0; i < DEPTH; i++) applyStimulus(0, 0, 0, 0, 0, 0, 1, i);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0);

    checkOutput("scoreboard drained", 128'(scq.size()), 128'(0));
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
